// File: rtl/qsys_timer_multi_pkg.sv
// Shared register map and bit-field definitions for the multi-channel interval timer.
package qsys_timer_multi_pkg;

    localparam int REG_W  = 2;
    localparam int CTRL_W = 16;

    typedef enum logic [REG_W-1:0] {
        REG_STATUS   = 2'd0,
        REG_CONTROL  = 2'd1,
        REG_PERIOD   = 2'd2,
        REG_SNAPSHOT = 2'd3
    } reg_sel_e;

    localparam int CTRL_ITO     = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_STOP    = 3;
    localparam int CTRL_PRE_LSB = 8;
    localparam int CTRL_PRE_MSB = 15;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/qsys_timer_channel.sv
// One timer channel: prescaler, down-counter, period/snapshot registers,
// control bits and the sticky timeout flag.
module qsys_timer_channel
    import qsys_timer_multi_pkg::*;
#(
    parameter int          COUNT_W      = 32,
    parameter logic [31:0] RESET_PERIOD = 32'd6250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_status,
    input  logic               wr_control,
    input  logic               wr_period,
    input  logic               wr_snapshot,
    input  logic [31:0]        writedata,
    output logic [CTRL_W-1:0]  control,
    output logic [COUNT_W-1:0] period,
    output logic [COUNT_W-1:0] snapshot,
    output logic               running,
    output logic               timeout_flag,
    output logic               irq
);

    localparam logic [COUNT_W-1:0] PERIOD_INIT = RESET_PERIOD[COUNT_W-1:0];

    logic [COUNT_W-1:0] counter;
    logic [7:0]         prescale;
    logic               tick;
    logic               timeout_evt;

    assign tick        = running && (prescale == control[CTRL_PRE_MSB:CTRL_PRE_LSB]);
    assign timeout_evt = tick && (counter == '0);
    assign irq         = timeout_flag & control[CTRL_ITO];

    always_ff @(posedge clk) begin
        if (reset) begin
            control      <= '0;
            period       <= PERIOD_INIT;
            counter      <= PERIOD_INIT;
            snapshot     <= '0;
            prescale     <= '0;
            running      <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            // NOTE: later non-blocking assignments in this block override earlier
            // ones, so the statement order below encodes the priority of bus
            // actions over counting (period reload beats everything).
            if (running)
                prescale <= tick ? '0 : prescale + 8'd1;

            if (tick) begin
                if (counter == '0) begin
                    counter <= period;
                    if (!control[CTRL_CONT])
                        running <= 1'b0;
                end else begin
                    counter <= counter - COUNT_W'(1);
                end
            end

            // A timeout in the same cycle as a clearing write must not be lost.
            if (timeout_evt)
                timeout_flag <= 1'b1;
            else if (wr_status)
                timeout_flag <= 1'b0;

            if (wr_control) begin
                control <= writedata[CTRL_W-1:0];
                if (writedata[CTRL_START])
                    running <= 1'b1;
                else if (writedata[CTRL_STOP])
                    running <= 1'b0;
            end

            if (wr_period) begin
                period   <= writedata[COUNT_W-1:0];
                counter  <= writedata[COUNT_W-1:0];
                prescale <= '0;
                running  <= 1'b0;
            end

            if (wr_snapshot)
                snapshot <= counter;
        end
    end

endmodule

// File: rtl/qsys_timer_multi.sv
// Multi-channel interval timer behind an Avalon-MM slave with 1-cycle read latency.
// Address layout is {channel, reg}; channels beyond NUM_CH read as zero.
module qsys_timer_multi
    import qsys_timer_multi_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          COUNT_W      = 32,
    parameter logic [31:0] RESET_PERIOD = 32'd6250000,
    localparam int         ADDR_W       = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq_ch,
    output logic              irq
);

    logic                           wr_stb;
    logic                           rd_stb;
    logic [ADDR_W-1:0]              ch_sel;
    reg_sel_e                       reg_sel;
    logic [NUM_CH-1:0]              running;
    logic [NUM_CH-1:0]              timeout_flag;
    logic [NUM_CH-1:0][CTRL_W-1:0]  control;
    logic [NUM_CH-1:0][COUNT_W-1:0] period;
    logic [NUM_CH-1:0][COUNT_W-1:0] snapshot;
    logic [31:0]                    rd_mux;

    assign wr_stb  = chipselect & ~write_n;
    assign rd_stb  = chipselect & write_n;
    assign ch_sel  = address >> REG_W;
    assign reg_sel = reg_sel_e'(address[REG_W-1:0]);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_stb && (ch_sel == ADDR_W'(i));

        qsys_timer_channel #(
            .COUNT_W      (COUNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr_status    (ch_wr && (reg_sel == REG_STATUS)),
            .wr_control   (ch_wr && (reg_sel == REG_CONTROL)),
            .wr_period    (ch_wr && (reg_sel == REG_PERIOD)),
            .wr_snapshot  (ch_wr && (reg_sel == REG_SNAPSHOT)),
            .writedata    (writedata),
            .control      (control[i]),
            .period       (period[i]),
            .snapshot     (snapshot[i]),
            .running      (running[i]),
            .timeout_flag (timeout_flag[i]),
            .irq          (irq_ch[i])
        );
    end

    assign irq = |irq_ch;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_STATUS: begin
                        rd_mux[STAT_TO]  = timeout_flag[i];
                        rd_mux[STAT_RUN] = running[i];
                    end
                    REG_CONTROL:  rd_mux = 32'(control[i]);
                    REG_PERIOD:   rd_mux = 32'(period[i]);
                    REG_SNAPSHOT: rd_mux = 32'(snapshot[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_stb)
            readdata <= rd_mux;
    end

endmodule
